// File: rtl/pkt_sched_pkg.sv
// Shared constants for the packet-boundary WRR / strict-priority scheduler.
package pkt_sched_pkg;

  localparam logic MODE_SP  = 1'b0;
  localparam logic MODE_WRR = 1'b1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping.
module rr_prio_pick #(
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_QUEUES)
) (
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [SEL_WIDTH-1:0]  ptr,
  output logic [SEL_WIDTH-1:0]  idx,
  output logic                  found
);

  localparam int unsigned SUM_WIDTH = SEL_WIDTH + 1;

  logic [2*NUM_QUEUES-1:0] req_dbl;
  logic [NUM_QUEUES-1:0]   rot;
  logic [SEL_WIDTH-1:0]    enc;
  logic [SUM_WIDTH-1:0]    sum;

  // Rotate so ptr lands at bit 0, encode the lowest set bit, then map back.
  always_comb begin
    req_dbl = {req, req};
    rot     = NUM_QUEUES'(req_dbl >> ptr);
    enc     = '0;
    found   = 1'b0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc   = SEL_WIDTH'(i);
        found = 1'b1;
      end
    end
    sum = SUM_WIDTH'(enc) + SUM_WIDTH'(ptr);
    if (sum >= SUM_WIDTH'(NUM_QUEUES)) begin
      sum = sum - SUM_WIDTH'(NUM_QUEUES);
    end
    idx = SEL_WIDTH'(sum);
  end

endmodule

// File: rtl/pkt_sched_wrr.sv
// Packet-boundary egress scheduler: strict priority or packet-count WRR,
// grant locked from selection until the accepted last beat.
module pkt_sched_wrr
  import pkt_sched_pkg::*;
#(
  parameter int unsigned NUM_QUEUES   = 4,
  parameter int unsigned SEL_WIDTH    = $clog2(NUM_QUEUES),
  parameter int unsigned WEIGHT_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_QUEUES-1:0]              q_valid,
  input  logic                               mode,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
  input  logic                               beat_fire,
  input  logic                               beat_last,
  output logic [SEL_WIDTH-1:0]               sel_out,
  output logic                               sel_valid
);

  localparam int unsigned NQ = NUM_QUEUES;
  localparam int unsigned WW = WEIGHT_WIDTH;

  logic [0:0]           state, state_nxt;
  logic [SEL_WIDTH-1:0] sel_nxt;
  logic                 sel_valid_nxt;
  logic [SEL_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
  logic                 gmode, gmode_nxt;
  logic [WW-1:0]        credit     [NQ];
  logic [WW-1:0]        credit_nxt [NQ];
  logic [WW-1:0]        wt_eff     [NQ];

  logic [NQ-1:0]        wrr_req;
  logic [NQ-1:0]        pick_req;
  logic [SEL_WIDTH-1:0] pick_ptr;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_found;
  logic                 reload;

  // Effective weights (0 counts as 1) and the credit-qualified request mask.
  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      wt_eff[i]  = (weights[i*WW +: WW] == '0) ? WW'(1) : weights[i*WW +: WW];
      wrr_req[i] = q_valid[i] & (credit[i] != '0);
    end
    reload   = (mode == MODE_WRR) && (wrr_req == '0) && (q_valid != '0);
    pick_req = ((mode == MODE_SP) || reload) ? q_valid : wrr_req;
    pick_ptr = (mode == MODE_SP) ? '0 : rr_ptr;
  end

  rr_prio_pick #(
    .NUM_QUEUES (NQ),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel_out;
    sel_valid_nxt = sel_valid;
    rr_ptr_nxt    = rr_ptr;
    gmode_nxt     = gmode;
    credit_nxt    = credit;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt     = ST_GRANT;
          sel_nxt       = pick_idx;
          sel_valid_nxt = 1'b1;
          gmode_nxt     = mode;
          if (reload) begin
            credit_nxt = wt_eff;
          end
        end
      end
      ST_GRANT: begin
        if (beat_fire && beat_last) begin
          state_nxt     = ST_IDLE;
          sel_valid_nxt = 1'b0;
          // Credit is charged per packet; the pointer moves once it runs out.
          if (gmode == MODE_WRR) begin
            credit_nxt[sel_out] = credit[sel_out] - WW'(1);
            if (credit[sel_out] == WW'(1)) begin
              rr_ptr_nxt = (sel_out == SEL_WIDTH'(NQ - 1)) ? '0 : sel_out + SEL_WIDTH'(1);
            end
          end
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        sel_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_out   <= '0;
      sel_valid <= 1'b0;
      rr_ptr    <= '0;
      gmode     <= MODE_SP;
      credit    <= wt_eff;
    end else begin
      state     <= state_nxt;
      sel_out   <= sel_nxt;
      sel_valid <= sel_valid_nxt;
      rr_ptr    <= rr_ptr_nxt;
      gmode     <= gmode_nxt;
      credit    <= credit_nxt;
    end
  end

endmodule

// File: tb/tb_pkt_sched_wrr.sv
// Self-checking bench for pkt_sched_wrr: directed table, WRR sequences,
// and randomized traffic against a queue-level reference model.
module tb_pkt_sched_wrr;

  localparam int NQ = 4;
  localparam int SW = 2;
  localparam int WW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NQ-1:0]      q_valid;
  logic               mode;
  logic [NQ*WW-1:0]   weights;
  logic               beat_fire;
  logic               beat_last;
  logic [SW-1:0]      sel_out;
  logic               sel_valid;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_cred [NQ];
  int m_ptr;
  int m_sel;
  bit m_valid;
  bit m_mode;

  typedef struct {
    logic          rst;
    logic [NQ-1:0] qv;
    logic          fire;
    logic          last;
    logic          ev;
    logic [SW-1:0] es;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pkt_sched_wrr #(
    .NUM_QUEUES   (NQ),
    .SEL_WIDTH    (SW),
    .WEIGHT_WIDTH (WW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .q_valid   (q_valid),
    .mode      (mode),
    .weights   (weights),
    .beat_fire (beat_fire),
    .beat_last (beat_last),
    .sel_out   (sel_out),
    .sel_valid (sel_valid)
  );

  function automatic int eff_w(int i);
    int w;
    w = int'(weights[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int find_from(logic [NQ-1:0] req, int start);
    for (int k = 0; k < NQ; k++) begin
      if (req[(start + k) % NQ]) return (start + k) % NQ;
    end
    return -1;
  endfunction

  // One clock edge of the scheduler, from the rules: pick, hold, charge credit.
  task automatic model_edge();
    logic [NQ-1:0] mask;
    int idx;
    if (rst) begin
      m_valid = 1'b0;
      m_sel   = 0;
      m_ptr   = 0;
      for (int i = 0; i < NQ; i++) m_cred[i] = eff_w(i);
    end else if (!m_valid) begin
      if (q_valid != '0) begin
        m_mode = mode;
        if (mode == 1'b0) begin
          idx = find_from(q_valid, 0);
        end else begin
          for (int i = 0; i < NQ; i++) mask[i] = q_valid[i] && (m_cred[i] != 0);
          idx = find_from(mask, m_ptr);
          if (idx < 0) begin
            for (int i = 0; i < NQ; i++) m_cred[i] = eff_w(i);
            idx = find_from(q_valid, m_ptr);
          end
        end
        m_sel   = idx;
        m_valid = 1'b1;
      end
    end else if (beat_fire && beat_last) begin
      m_valid = 1'b0;
      if (m_mode) begin
        m_cred[m_sel] = m_cred[m_sel] - 1;
        if (m_cred[m_sel] == 0) m_ptr = (m_sel + 1) % NQ;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    vectors++;
    if (sel_valid !== m_valid || sel_out !== SW'(m_sel)) begin
      miscompares++;
      $display("FAIL model t=%0t: got valid=%0b sel=%0d, expected valid=%0b sel=%0d",
               $time, sel_valid, sel_out, m_valid, m_sel);
    end
  endtask

  task automatic chk(input string name, input logic ev, input logic [SW-1:0] es);
    vectors++;
    if (sel_valid !== ev || sel_out !== es) begin
      miscompares++;
      $display("FAIL %s t=%0t: got valid=%0b sel=%0d, expected valid=%0b sel=%0d",
               name, $time, sel_valid, sel_out, ev, es);
    end
  endtask

  function automatic void add(logic r, logic [NQ-1:0] qv, logic f, logic l,
                              logic ev, logic [SW-1:0] es);
    vec_t v;
    v.rst = r; v.qv = qv; v.fire = f; v.last = l; v.ev = ev; v.es = es;
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b1; beat_fire = 1'b0; beat_last = 1'b0; q_valid = '0;
    step();
    chk("reset", 1'b0, '0);
    rst = 1'b0;
  endtask

  int wseq [14] = '{0, 0, 0, 1, 1, 2, 3, 0, 0, 0, 1, 1, 2, 3};
  int zseq [6]  = '{1, 3, 1, 3, 1, 3};

  initial begin
    rst = 1'b1; q_valid = '0; mode = 1'b0; weights = 32'h01010101;
    beat_fire = 1'b0; beat_last = 1'b0;
    m_valid = 1'b0; m_sel = 0; m_ptr = 0; m_mode = 1'b0;
    for (int i = 0; i < NQ; i++) m_cred[i] = 1;

    // rst qv fire last -> valid sel
    add(1, 4'b0000, 0, 0, 0, 0);
    // SP basic
    add(0, 4'b1010, 0, 0, 1, 1);
    add(0, 4'b1010, 1, 0, 1, 1);
    add(0, 4'b1000, 1, 1, 0, 1);
    add(0, 4'b1000, 0, 0, 1, 3);
    add(0, 4'b0000, 1, 1, 0, 3);
    // SP lock: 5-beat packet on queue 2, queue 0 arrives at beat 2
    add(0, 4'b0100, 0, 0, 1, 2);
    add(0, 4'b0100, 1, 0, 1, 2);
    add(0, 4'b0101, 1, 0, 1, 2);
    add(0, 4'b0101, 1, 0, 1, 2);
    add(0, 4'b0101, 1, 0, 1, 2);
    add(0, 4'b0101, 1, 1, 0, 2);
    add(0, 4'b0101, 0, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 0, 0);
    // stray beats while idle
    add(0, 4'b0000, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0);
    // reset during beat 3 of a queue-2 packet
    add(0, 4'b0100, 0, 0, 1, 2);
    add(0, 4'b0100, 1, 0, 1, 2);
    add(0, 4'b0100, 1, 0, 1, 2);
    add(1, 4'b0100, 1, 0, 0, 0);
    add(0, 4'b0001, 0, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 0, 0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst; q_valid = tbl[k].qv;
      beat_fire = tbl[k].fire; beat_last = tbl[k].last;
      step();
      chk($sformatf("table[%0d]", k), tbl[k].ev, tbl[k].es);
    end

    // WRR weights q0=3 q1=2 q2=1 q3=1, all valid, single-beat packets
    weights = {8'd1, 8'd1, 8'd2, 8'd3};
    mode = 1'b1;
    do_reset();
    q_valid = 4'b1111;
    for (int k = 0; k < 14; k++) begin
      beat_fire = 1'b0; beat_last = 1'b0;
      step();
      chk($sformatf("wrr_grant[%0d]", k), 1'b1, SW'(wseq[k]));
      beat_fire = 1'b1; beat_last = 1'b1;
      step();
      chk($sformatf("wrr_release[%0d]", k), 1'b0, SW'(wseq[k]));
    end

    // Zero weight on q1, only q1 and q3 valid
    weights = {8'd1, 8'd5, 8'd0, 8'd5};
    do_reset();
    q_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      beat_fire = 1'b0; beat_last = 1'b0;
      step();
      chk($sformatf("zero_w_grant[%0d]", k), 1'b1, SW'(zseq[k]));
      beat_fire = 1'b1; beat_last = 1'b1;
      step();
      chk($sformatf("zero_w_release[%0d]", k), 1'b0, SW'(zseq[k]));
    end

    // Randomized traffic, model compared every cycle
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < NQ; i++) weights[i*WW +: WW] = WW'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      q_valid   = NQ'($urandom_range(0, 15));
      beat_fire = 1'($urandom_range(0, 1));
      beat_last = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pkt_sched_wrr.md
# pkt_sched_wrr

Parametrised packet-boundary scheduler that selects which of `NUM_QUEUES` egress packet FIFOs drives the shared output mux. It supports strict priority and weighted round robin (WRR, packet-count credits), selectable at run time. The selection is locked for a whole packet and released on the accepted last beat. It sits between the per-class packet FIFOs and the output AXI-Stream mux in the packet_scheduling path, and drives the mux select and enable.

## Interface
Parameters:
- `NUM_QUEUES`, 4: number of queues, ≥2.
- `SEL_WIDTH`, `$clog2(NUM_QUEUES)`: select width.
- `WEIGHT_WIDTH`, 8: per-queue weight width, in packets per round.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `q_valid` in `NUM_QUEUES`: queue i holds at least one complete packet.
- `mode` in 1: 0 = strict priority, 1 = WRR. Sampled only in IDLE.
- `weights` in `NUM_QUEUES*WEIGHT_WIDTH`: weight of queue i at bits `[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]`.
- `beat_fire` in 1: the output mux accepted a beat from the selected queue (tvalid & tready).
- `beat_last` in 1: tlast of that beat. Meaningful only with `beat_fire`.
- `sel_out` out `SEL_WIDTH`: selected queue index.
- `sel_valid` out 1: `sel_out` is granted; mux enable.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: `sel_out` locked until end of packet.
- IDLE → GRANT: when the pick logic finds a candidate, register `sel_out` and set `sel_valid`.
- GRANT → IDLE: on `beat_fire & beat_last`. `sel_valid` clears on the next edge.
- Strict priority:
  - Candidate = lowest-index asserted `q_valid`; index 0 is highest priority.
  - Credits and `rr_ptr` are not touched.
- WRR:
  - Per-queue credit counter, `WEIGHT_WIDTH` bits wide.
  - Candidate = first queue at or after `rr_ptr`, wrapping modulo `NUM_QUEUES`, with `q_valid=1` and credit ≠ 0.
  - If no valid queue has credit but some queue is valid, reload every credit from `weights` and pick from `rr_ptr` using the reloaded values, in the same cycle.
  - A weight of 0 is treated as 1, so no queue starves.
- On packet end in WRR:
  - Decrement the credit of `sel_out`.
  - If the resulting credit is 0, set `rr_ptr` to `sel_out+1` (wrapping from `NUM_QUEUES-1` to 0). Otherwise `rr_ptr` stays, so the same queue continues while it has credit.
- Weight changes take effect at the next reload only.
- Mode changes during GRANT are ignored until IDLE. Switching SP→WRR keeps the existing credits and `rr_ptr`.
- `beat_fire` while in IDLE is ignored.
- Deassertion of `q_valid[sel_out]` during GRANT is ignored: the grant holds until the last beat.
- Reset values:
  - `sel_out`=0, `sel_valid`=0, state IDLE, `rr_ptr`=0.
  - All credits loaded from `weights`, with 0→1.
- Reset mid-packet drops the grant immediately (the outputs above on the next edge). Flushing the upstream packet is not this block's job.

## Timing
- Decision latency: `q_valid` asserted in cycle t while IDLE → `sel_valid`=1 and `sel_out` valid at t+1.
- Release: `beat_fire & beat_last` at cycle t → `sel_valid`=0 at t+1. The earliest next grant is t+2, a mandatory one-cycle bubble per packet.
- Single-beat packet: grant at t+1 and last beat at t+1 → `sel_valid` low at t+2.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `pkt_sched_pkg`:
  - `MODE_SP`=1'b0, `MODE_WRR`=1'b1.
  - FSM state encoding `ST_IDLE`, `ST_GRANT`.
- Sub-module `rr_prio_pick`: combinational. Takes a `NUM_QUEUES` request vector and a start pointer, rotates the vector, priority-encodes it, and un-rotates the index. Outputs index and found.
  - Strict priority uses it with pointer 0.
  - WRR uses it with `rr_ptr` and the mask `q_valid & credit≠0`, or `q_valid` alone on the reload cycle.

## Test plan
- **SP basic:** `mode`=0, `q_valid`=4'b1010 → `sel_out`=1, `sel_valid`=1 one cycle later. After that packet's last beat, `q_valid`=4'b1000 → bubble, then `sel_out`=3.
- **SP lock:** granted queue 2 with a 5-beat packet; `q_valid[0]` rises at beat 2 → `sel_out` stays 2 through beat 5, then 0 after the bubble.
- **WRR weights:** `weights`={1,1,2,3} (q3..q0), all queues always valid, single-beat packets → grant sequence 0,0,0,1,1,2,3, then the reload repeats the pattern.
- **WRR zero weight / skip:** `weights` q1=0, only q1 and q3 valid → q1 gets 1 packet per round, alternating 1,3,1,3…
- **Idle and stray fire:** `beat_fire` pulses with `sel_valid`=0 → no state change. `q_valid`=0 → `sel_valid` stays 0 and credits are unchanged.
- **Reset mid-packet:** assert `rst` during beat 3 of a queue-2 packet → next edge `sel_valid`=0, `sel_out`=0, `rr_ptr`=0, credits equal `weights`. With `q_valid`=4'b0001 after reset → `sel_out`=0 at +1.
